// File: rtl/fpu_issue_ctrl_if.sv
// Bundled request, datapath and response channels of the FP issue controller.
// The slave modport is the controller's view; master is the core/datapath side.
interface fpu_issue_ctrl_if;
  // Request channel from FP decode/issue
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_rm;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_rs2_lsb;
  logic [4:0]  req_rd;
  logic [2:0]  frm;
  logic        flush;

  // Arithmetic datapath
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_rs2_lsb;
  logic [31:0] fpu_out;
  logic        fpu_done;
  logic        fpu_overflow;
  logic        fpu_underflow;
  logic        fpu_invalid;
  logic        fpu_inexact;
  logic        fpu_div_by_zero;

  // Response channel and fcsr flag update
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_illegal;
  logic        resp_timeout;
  logic        fflags_set;
  logic [4:0]  fflags_val;

  modport slave (
    input  req_valid, req_op, req_rm, req_a, req_b, req_rs2_lsb, req_rd, frm, flush,
    output req_ready,
    output fpu_start, fpu_op, fpu_rm, fpu_a, fpu_b, fpu_rs2_lsb,
    input  fpu_out, fpu_done, fpu_overflow, fpu_underflow, fpu_invalid, fpu_inexact,
    input  fpu_div_by_zero,
    output resp_valid, resp_data, resp_rd, resp_illegal, resp_timeout, fflags_set, fflags_val,
    input  resp_ready
  );

  modport master (
    output req_valid, req_op, req_rm, req_a, req_b, req_rs2_lsb, req_rd, frm, flush,
    input  req_ready,
    input  fpu_start, fpu_op, fpu_rm, fpu_a, fpu_b, fpu_rs2_lsb,
    output fpu_out, fpu_done, fpu_overflow, fpu_underflow, fpu_invalid, fpu_inexact,
    output fpu_div_by_zero,
    input  resp_valid, resp_data, resp_rd, resp_illegal, resp_timeout, fflags_set, fflags_val,
    output resp_ready
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding FP issue sequencer: registers the op, resolves dynamic rounding,
// holds start until done or watchdog expiry, then presents the result until consumed.
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] CANON_NAN      = 32'h7FC00000
) (
  input logic             clk,
  input logic             reset,
  fpu_issue_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e          r_state, w_state;
  logic [4:0]      r_op, w_op;
  logic [2:0]      r_rm, w_rm;
  logic [31:0]     r_a, w_a;
  logic [31:0]     r_b, w_b;
  logic            r_rs2, w_rs2;
  logic [4:0]      r_rd, w_rd;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic [31:0]     r_data, w_data;
  logic [4:0]      r_flags, w_flags;
  logic            r_fset, w_fset;
  logic            r_illegal, w_illegal;
  logic            r_timeout, w_timeout;

  logic            w_round_op;
  logic [2:0]      w_rm_res;
  logic            w_rm_bad;
  logic [4:0]      w_dp_flags;

  // For rounding ops rm=111 means "use frm"; elsewhere rm is a function selector.
  always_comb begin
    case (bus.req_op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011,
      5'b01011, 5'b11000, 5'b11010: w_round_op = 1'b1;
      default:                      w_round_op = 1'b0;
    endcase
    w_rm_res = (w_round_op && (bus.req_rm == 3'b111)) ? bus.frm : bus.req_rm;
    w_rm_bad = w_round_op &&
               ((w_rm_res == 3'b101) || (w_rm_res == 3'b110) || (w_rm_res == 3'b111));
  end

  assign w_dp_flags = {bus.fpu_invalid, bus.fpu_div_by_zero, bus.fpu_overflow,
                       bus.fpu_underflow, bus.fpu_inexact};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_op      <= '0;
      r_rm      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rs2     <= 1'b0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_flags   <= '0;
      r_fset    <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_op      <= w_op;
      r_rm      <= w_rm;
      r_a       <= w_a;
      r_b       <= w_b;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_cnt     <= w_cnt;
      r_data    <= w_data;
      r_flags   <= w_flags;
      r_fset    <= w_fset;
      r_illegal <= w_illegal;
      r_timeout <= w_timeout;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_op      = r_op;
    w_rm      = r_rm;
    w_a       = r_a;
    w_b       = r_b;
    w_rs2     = r_rs2;
    w_rd      = r_rd;
    w_cnt     = r_cnt;
    w_data    = r_data;
    w_flags   = r_flags;
    w_fset    = 1'b0;
    w_illegal = r_illegal;
    w_timeout = r_timeout;

    unique case (r_state)
      StIdle: begin
        if (bus.req_valid && !bus.flush) begin
          w_op      = bus.req_op;
          w_rm      = w_rm_res;
          w_a       = bus.req_a;
          w_b       = bus.req_b;
          w_rs2     = bus.req_rs2_lsb;
          w_rd      = bus.req_rd;
          w_cnt     = '0;
          w_data    = '0;
          w_flags   = '0;
          w_timeout = 1'b0;
          w_illegal = w_rm_bad;
          w_state   = w_rm_bad ? StResp : StExec;
        end
      end

      StExec: begin
        // flush beats a coincident done: nothing is reported or flagged
        if (bus.flush) begin
          w_state = StIdle;
          w_cnt   = '0;
        end else if (bus.fpu_done) begin
          w_data  = bus.fpu_out;
          w_flags = w_dp_flags;
          w_fset  = 1'b1;
          w_cnt   = '0;
          w_state = StResp;
        end else if (r_cnt == CntLast) begin
          w_data    = CANON_NAN;
          w_flags   = 5'b10000;
          w_fset    = 1'b1;
          w_timeout = 1'b1;
          w_cnt     = '0;
          w_state   = StResp;
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end

      StResp: begin
        if (bus.flush || bus.resp_ready) begin
          w_illegal = 1'b0;
          w_timeout = 1'b0;
          w_state   = StIdle;
        end
      end

      default: begin
        w_state = StIdle;
      end
    endcase
  end

  assign bus.req_ready    = (r_state == StIdle) && !reset && !bus.flush;
  assign bus.fpu_start    = (r_state == StExec);
  assign bus.fpu_op       = r_op;
  assign bus.fpu_rm       = r_rm;
  assign bus.fpu_a        = r_a;
  assign bus.fpu_b        = r_b;
  assign bus.fpu_rs2_lsb  = r_rs2;
  assign bus.resp_valid   = (r_state == StResp);
  assign bus.resp_data    = r_data;
  assign bus.resp_rd      = r_rd;
  assign bus.resp_illegal = r_illegal;
  assign bus.resp_timeout = r_timeout;
  assign bus.fflags_set   = r_fset;
  assign bus.fflags_val   = r_flags;

endmodule
